// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Optional feature macro: PC_STACK_CHK_EN (RAS overflow/underflow checking).
package pc_pkg;

   localparam int PC_D_DEF        = 10;
   localparam int PC_O_DEF        = 8;
   localparam int PC_S_DEF        = 4;
   localparam int PC_RESET_PC_DEF = 0;

   typedef enum logic [2:0] {
      PC_INC,
      PC_REL,
      PC_ABS,
      PC_CALL,
      PC_RET,
      PC_HOLD
   } pc_op_e;

   typedef enum logic {
      RUN,
      HALT
   } pc_state_e;

   // Priority encoder: hold beats ret, ret beats call, call beats jump,
   // jump beats branch, and increment is the fallback.
   function automatic pc_op_e pc_encode(input logic hold,
                                        input logic ret,
                                        input logic call,
                                        input logic jmp_abs,
                                        input logic br_taken);
      pc_op_e op;
      if (hold)          op = PC_HOLD;
      else if (ret)      op = PC_RET;
      else if (call)     op = PC_CALL;
      else if (jmp_abs)  op = PC_ABS;
      else if (br_taken) op = PC_REL;
      else               op = PC_INC;
      return op;
   endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control/status bundle between the decoder side and the PC sequencer.
// Optional feature macro: PC_STACK_CHK_EN adds stack_err.
interface pc_seq_if #(
   parameter int D = 10,
   parameter int O = 8,
   parameter int S = 4
);
   localparam int CW = $clog2(S + 1);

   logic          stall;
   logic          jmp_abs;
   logic [D-1:0]  abs_addr;
   logic          br_taken;
   logic [O-1:0]  offset;
   logic          call;
   logic          ret;
   logic          halt_req;
   logic [D-1:0]  prog_ctr;
   logic          halted;
   logic [CW-1:0] ras_cnt;
`ifdef PC_STACK_CHK_EN
   logic          stack_err;
`endif

   modport master (
      output stall, jmp_abs, abs_addr, br_taken, offset, call, ret, halt_req,
`ifdef PC_STACK_CHK_EN
      input  stack_err,
`endif
      input  prog_ctr, halted, ras_cnt
   );

   modport slave (
      input  stall, jmp_abs, abs_addr, br_taken, offset, call, ret, halt_req,
`ifdef PC_STACK_CHK_EN
      output stack_err,
`endif
      output prog_ctr, halted, ras_cnt
   );

endinterface

// File: rtl/pc_seq_ret_stack.sv
// Return-address stack: circular buffer of S entries with a top pointer.
// Optional feature macro: PC_STACK_CHK_EN blocks overflow/underflow and flags err.
module ret_stack
   import pc_pkg::*;
#(
   parameter int D = PC_D_DEF,
   parameter int S = PC_S_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [D-1:0]           wdata,
   output logic [D-1:0]           rdata,
   output logic [$clog2(S+1)-1:0] count,
`ifdef PC_STACK_CHK_EN
   output logic                   err,
`endif
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(S);
   localparam int CW = $clog2(S + 1);

   logic [PW-1:0] ptr_reg, ptr_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [PW-1:0] wr_ptr;
   logic          do_push, do_pop;
   logic [D-1:0]  rd_arr [S];

   assign full   = (cnt_reg == CW'(S));
   assign empty  = (cnt_reg == '0);
   assign wr_ptr = ptr_reg + PW'(1);

`ifdef PC_STACK_CHK_EN
   logic err_reg;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign err     = err_reg;

   always_ff @(posedge clk) begin
      if (reset)
         err_reg <= 1'b0;
      else if ((push & full) | (pop & empty))
         err_reg <= 1'b1;
   end
`else
   // Without checking, the buffer simply wraps in both directions.
   assign do_push = push;
   assign do_pop  = pop;
`endif

   always_comb begin
      ptr_next = ptr_reg;
      cnt_next = cnt_reg;
      if (do_pop) begin
         ptr_next = ptr_reg - PW'(1);
         cnt_next = empty ? cnt_reg : cnt_reg - CW'(1);
      end else if (do_push) begin
         ptr_next = wr_ptr;
         cnt_next = full ? cnt_reg : cnt_reg + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
         cnt_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
         cnt_reg <= cnt_next;
      end
   end

   // Entry contents carry no reset; stale data is architecturally visible.
   for (genvar gi = 0; gi < S; gi++) begin : g_entry
      logic [D-1:0] entry_reg;

      always_ff @(posedge clk) begin
         if (do_push && !do_pop && wr_ptr == PW'(gi))
            entry_reg <= wdata;
      end

      assign rd_arr[gi] = entry_reg;
   end

   assign rdata = rd_arr[ptr_reg];
   assign count = cnt_reg;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: priority mux, PC adders, RUN/HALT FSM and a RAS.
// Optional feature macro: PC_STACK_CHK_EN (checked RAS with sticky stack_err).
module pc_seq
   import pc_pkg::*;
#(
   parameter int          D        = PC_D_DEF,
   parameter int          O        = PC_O_DEF,
   parameter int          S        = PC_S_DEF,
   parameter int unsigned RESET_PC = PC_RESET_PC_DEF
) (
   input  logic    clk,
   input  logic    reset,
   pc_seq_if.slave bus
);
   localparam int CW = $clog2(S + 1);

   pc_state_e     state_reg, state_next;
   logic [D-1:0]  pc_reg, pc_next;
   logic [D-1:0]  pc_inc, pc_rel, off_ext;
   logic [D-1:0]  ras_rdata;
   logic [CW-1:0] ras_count;
   logic          ras_full, ras_empty;
   logic          ras_push, ras_pop;
   logic          hold;
   pc_op_e        op;

   assign off_ext = D'($signed(bus.offset));
   assign pc_inc  = pc_reg + D'(1);
   assign pc_rel  = pc_reg + off_ext;

   // halt_req freezes the PC on the very edge it is accepted.
   assign hold = bus.stall | bus.halt_req | (state_reg == HALT);
   assign op   = pc_encode(hold, bus.ret, bus.call, bus.jmp_abs, bus.br_taken);

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;

      if (state_reg == RUN && !bus.stall && bus.halt_req)
         state_next = HALT;

      case (op)
         PC_RET: begin
            ras_pop = 1'b1;
`ifdef PC_STACK_CHK_EN
            pc_next = ras_empty ? pc_inc : ras_rdata;
`else
            pc_next = ras_rdata;
`endif
         end
         PC_CALL: begin
            ras_push = 1'b1;
            pc_next  = bus.abs_addr;
         end
         PC_ABS:  pc_next = bus.abs_addr;
         PC_REL:  pc_next = pc_rel;
         PC_INC:  pc_next = pc_inc;
         default: pc_next = pc_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= RUN;
         pc_reg    <= D'(RESET_PC);
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   ret_stack #(
      .D (D),
      .S (S)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (ras_push),
      .pop   (ras_pop),
      .wdata (pc_inc),
      .rdata (ras_rdata),
      .count (ras_count),
`ifdef PC_STACK_CHK_EN
      .err   (bus.stack_err),
`endif
      .full  (ras_full),
      .empty (ras_empty)
   );

   // Occupancy flags are informational here except in the checked build.
   logic ras_flags_unused;
   assign ras_flags_unused = ras_full ^ ras_empty;

   assign bus.prog_ctr = pc_reg;
   assign bus.halted   = (state_reg == HALT);
   assign bus.ras_cnt  = ras_count;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a main D=10 instance plus a D=4 instance for wrap.
// Optional feature macro: PC_STACK_CHK_EN switches the RAS boundary expectations.
module tb_pc_seq;
   import pc_pkg::*;

   localparam int D = 10;
   localparam int O = 8;
   localparam int S = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pc_seq_if #(.D(D), .O(O), .S(S)) bus ();
   pc_seq_if #(.D(4), .O(4), .S(2)) bus4 ();

   pc_seq #(.D(D), .O(O), .S(S), .RESET_PC(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   pc_seq #(.D(4), .O(4), .S(2), .RESET_PC(14)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   task automatic clr;
      bus.stall = 0; bus.jmp_abs = 0; bus.abs_addr = '0; bus.br_taken = 0;
      bus.offset = '0; bus.call = 0; bus.ret = 0; bus.halt_req = 0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
      $display("step %-12s observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic jump(input int addr);
      clr; bus.jmp_abs = 1; bus.abs_addr = D'(addr);
      tick;
      chk("jmp", 32'(bus.prog_ctr), 32'(addr));
   endtask

   initial begin
      int exp_pc [5];
      int exp_cnt [5];

      clr;
      bus4.stall = 0; bus4.jmp_abs = 0; bus4.abs_addr = '0; bus4.br_taken = 0;
      bus4.offset = '0; bus4.call = 0; bus4.ret = 0; bus4.halt_req = 0;

      // Reset and free-running increment
      reset = 1;
      tick;
      reset = 0;
      chk("rst_pc", 32'(bus.prog_ctr), 0);
      chk("rst_halt", 32'(bus.halted), 0);
      chk("rst_cnt", 32'(bus.ras_cnt), 0);
      chk("d4_rst", 32'(bus4.prog_ctr), 14);
`ifdef PC_STACK_CHK_EN
      chk("rst_err", 32'(bus.stack_err), 0);
`endif
      for (int i = 1; i <= 5; i++) begin
         tick;
         chk("inc", 32'(bus.prog_ctr), 32'(i));
         if (i == 1) chk("d4_inc", 32'(bus4.prog_ctr), 15);
         if (i == 2) chk("d4_wrap", 32'(bus4.prog_ctr), 0);
      end

      // Relative branches and stall (stall masks jmp/halt_req too)
      jump(20);
      clr; bus.br_taken = 1; bus.offset = 8'hFC;
      tick;
      chk("br_neg", 32'(bus.prog_ctr), 16);
      clr; bus.br_taken = 1; bus.offset = 8'h7F;
      tick;
      chk("br_pos", 32'(bus.prog_ctr), 143);
      for (int i = 0; i < 3; i++) begin
         clr; bus.stall = 1; bus.br_taken = 1; bus.offset = 8'h10;
         bus.jmp_abs = 1; bus.abs_addr = 10'd9; bus.halt_req = 1;
         tick;
         chk("stall_pc", 32'(bus.prog_ctr), 143);
         chk("stall_halt", 32'(bus.halted), 0);
      end

      // Simple call / return
      jump(5);
      clr; bus.call = 1; bus.abs_addr = 10'd100;
      tick;
      chk("call_pc", 32'(bus.prog_ctr), 100);
      chk("call_cnt", 32'(bus.ras_cnt), 1);
      clr;
      tick;
      tick;
      chk("idle_pc", 32'(bus.prog_ctr), 102);
      clr; bus.ret = 1;
      tick;
      chk("ret_pc", 32'(bus.prog_ctr), 6);
      chk("ret_cnt", 32'(bus.ras_cnt), 0);

      // Self-loop and modulo wrap at D=10
      clr; bus.br_taken = 1; bus.offset = 8'h00;
      tick;
      chk("br_zero", 32'(bus.prog_ctr), 6);
      jump(1023);
      clr;
      tick;
      chk("wrap", 32'(bus.prog_ctr), 0);
      clr; bus.br_taken = 1; bus.offset = 8'hFC;
      tick;
      chk("br_wrap", 32'(bus.prog_ctr), 1020);

      // Nested calls one deeper than the RAS
      jump(200);
      for (int k = 0; k < 5; k++) begin
         clr; bus.call = 1; bus.abs_addr = 10'(300 + 100 * k);
         tick;
         chk("ncall_pc", 32'(bus.prog_ctr), 32'(300 + 100 * k));
         chk("ncall_cnt", 32'(bus.ras_cnt), (k < 4) ? 32'(k + 1) : 32'd4);
`ifdef PC_STACK_CHK_EN
         chk("ncall_err", 32'(bus.stack_err), (k == 4) ? 32'd1 : 32'd0);
`endif
      end
`ifdef PC_STACK_CHK_EN
      exp_pc = '{501, 401, 301, 201, 202};
`else
      exp_pc = '{601, 501, 401, 301, 601};
`endif
      exp_cnt = '{3, 2, 1, 0, 0};
      for (int k = 0; k < 5; k++) begin
         clr; bus.ret = 1;
         tick;
         chk("nret_pc", 32'(bus.prog_ctr), 32'(exp_pc[k]));
         chk("nret_cnt", 32'(bus.ras_cnt), 32'(exp_cnt[k]));
      end
`ifdef PC_STACK_CHK_EN
      chk("nret_err", 32'(bus.stack_err), 1);
`endif

      // Same-cycle priority
      jump(50);
      clr; bus.call = 1; bus.abs_addr = 10'd80;
      tick;
      chk("pcall_pc", 32'(bus.prog_ctr), 80);
      clr; bus.ret = 1; bus.call = 1; bus.jmp_abs = 1; bus.br_taken = 1;
      bus.abs_addr = 10'd999; bus.offset = 8'h05;
      tick;
      chk("all_pc", 32'(bus.prog_ctr), 51);
      chk("all_cnt", 32'(bus.ras_cnt), 0);
      clr; bus.call = 1; bus.jmp_abs = 1; bus.abs_addr = 10'd123;
      tick;
      chk("cj_pc", 32'(bus.prog_ctr), 123);
      chk("cj_cnt", 32'(bus.ras_cnt), 1);
      clr; bus.ret = 1;
      tick;
      chk("cj_ret", 32'(bus.prog_ctr), 52);

      // Halt, then reset out of it
      jump(33);
      clr; bus.halt_req = 1; bus.jmp_abs = 1; bus.abs_addr = 10'd77;
      tick;
      chk("halt_pc", 32'(bus.prog_ctr), 33);
      chk("halt_flag", 32'(bus.halted), 1);
      for (int i = 0; i < 2; i++) begin
         clr; bus.jmp_abs = 1; bus.call = 1; bus.abs_addr = 10'd400;
         tick;
         chk("hold_pc", 32'(bus.prog_ctr), 33);
         chk("hold_flag", 32'(bus.halted), 1);
         chk("hold_cnt", 32'(bus.ras_cnt), 0);
      end
      clr; reset = 1;
      tick;
      reset = 0;
      chk("rst2_pc", 32'(bus.prog_ctr), 0);
      chk("rst2_halt", 32'(bus.halted), 0);
      chk("rst2_cnt", 32'(bus.ras_cnt), 0);
`ifdef PC_STACK_CHK_EN
      chk("rst2_err", 32'(bus.stack_err), 0);
`endif
      tick;
      chk("post_inc", 32'(bus.prog_ctr), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
